// File: rtl/laser_cover_checker.sv
// Recounts how many LASER targets fall within the coverage radius of either reported centre.
// Optional best-round tracking is enabled by defining LASER_CHK_BEST_EN.
module laser_cover_checker #(
  parameter int NUM_TARGETS = 40,
  parameter int COORD_W     = 4,
  parameter int RADIUS_SQ   = 16,
  parameter int CNT_W       = 6
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               in_valid_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic               done_i,
  input  logic [COORD_W-1:0] c1x_i,
  input  logic [COORD_W-1:0] c1y_i,
  input  logic [COORD_W-1:0] c2x_i,
  input  logic [COORD_W-1:0] c2y_i,
  output logic [CNT_W-1:0]   cover_cnt_o,
  output logic               chk_valid_o,
  output logic               busy_o,
  output logic               err_o,
  output logic               ovf_o
`ifdef LASER_CHK_BEST_EN
  ,
  output logic [CNT_W-1:0]   best_cnt_o,
  output logic [COORD_W-1:0] best_c1x_o,
  output logic [COORD_W-1:0] best_c1y_o,
  output logic [COORD_W-1:0] best_c2x_o,
  output logic [COORD_W-1:0] best_c2y_o
`endif
);

  localparam int IDX_W = $clog2(NUM_TARGETS);
  localparam int D_W   = 2 * COORD_W + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TARGETS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_REPORT = 2'd2} state_t;

  function automatic logic [D_W-1:0] sq_dist(input logic [COORD_W-1:0] ax, input logic [COORD_W-1:0] ay,
                                             input logic [COORD_W-1:0] bx, input logic [COORD_W-1:0] by);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    dx = (ax >= bx) ? (ax - bx) : (bx - ax);
    dy = (ay >= by) ? (ay - by) : (by - ay);
    return (D_W'(dx) * D_W'(dx)) + (D_W'(dy) * D_W'(dy));
  endfunction

  logic [COORD_W-1:0] bx_q [2][NUM_TARGETS];
  logic [COORD_W-1:0] by_q [2][NUM_TARGETS];
  logic [IDX_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic               wr_bank_q, wr_bank_d;
  logic [1:0]         bank_full_q, bank_full_d;
  logic               ovf_q, ovf_d;
  logic               wr_en_s;

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   acc_q, cover_q;
  logic               scan_bank_q, chk_valid_q, busy_q, err_q;
  logic [COORD_W-1:0] c1x_q, c1y_q, c2x_q, c2y_q;
  logic               hit_s;

  // Loader next state: drop samples aimed at a full bank, and let a scanner release win over a fill.
  always_comb begin
    bank_full_d = bank_full_q;
    wr_cnt_d    = wr_cnt_q;
    wr_bank_d   = wr_bank_q;
    ovf_d       = ovf_q;
    wr_en_s     = 1'b0;
    if (in_valid_i) begin
      if (bank_full_q[wr_bank_q]) begin
        ovf_d = 1'b1;
      end else begin
        wr_en_s = 1'b1;
        if (wr_cnt_q == IDX_LAST) begin
          bank_full_d[wr_bank_q] = 1'b1;
          wr_bank_d              = ~wr_bank_q;
          wr_cnt_d               = IDX_ZERO;
        end else begin
          wr_cnt_d = wr_cnt_q + IDX_ONE;
        end
      end
    end else begin
      wr_en_s = 1'b0;
    end
    if (state_q == S_REPORT) begin
      bank_full_d[scan_bank_q] = 1'b0;
    end else begin
      bank_full_d = bank_full_d;
    end
  end

  // Loader bookkeeping registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_cnt_q    <= IDX_ZERO;
      wr_bank_q   <= 1'b0;
      bank_full_q <= 2'b00;
      ovf_q       <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      bank_full_q <= bank_full_d;
      ovf_q       <= ovf_d;
    end
  end

  // Ping-pong target storage.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      bx_q[wr_bank_q][wr_cnt_q] <= x_i;
      by_q[wr_bank_q][wr_cnt_q] <= y_i;
    end
  end

  assign hit_s = (sq_dist(bx_q[scan_bank_q][idx_q], by_q[scan_bank_q][idx_q], c1x_q, c1y_q) <= D_W'(RADIUS_SQ)) ||
                 (sq_dist(bx_q[scan_bank_q][idx_q], by_q[scan_bank_q][idx_q], c2x_q, c2y_q) <= D_W'(RADIUS_SQ));

`ifdef LASER_CHK_BEST_EN
  logic [CNT_W-1:0]   best_cnt_q;
  logic [COORD_W-1:0] best_c1x_q, best_c1y_q, best_c2x_q, best_c2y_q;
`endif

  // Scanner FSM with registered report outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      idx_q       <= IDX_ZERO;
      acc_q       <= CNT_ZERO;
      cover_q     <= CNT_ZERO;
      scan_bank_q <= 1'b0;
      chk_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      c1x_q       <= {COORD_W{1'b0}};
      c1y_q       <= {COORD_W{1'b0}};
      c2x_q       <= {COORD_W{1'b0}};
      c2y_q       <= {COORD_W{1'b0}};
`ifdef LASER_CHK_BEST_EN
      best_cnt_q  <= CNT_ZERO;
      best_c1x_q  <= {COORD_W{1'b0}};
      best_c1y_q  <= {COORD_W{1'b0}};
      best_c2x_q  <= {COORD_W{1'b0}};
      best_c2y_q  <= {COORD_W{1'b0}};
`endif
    end else begin
      chk_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (done_i) begin
            if (|bank_full_q) begin
              // With both banks full the write pointer has wrapped onto the older one.
              scan_bank_q <= (&bank_full_q) ? wr_bank_q : bank_full_q[1];
              c1x_q       <= c1x_i;
              c1y_q       <= c1y_i;
              c2x_q       <= c2x_i;
              c2y_q       <= c2y_i;
              idx_q       <= IDX_ZERO;
              acc_q       <= CNT_ZERO;
              busy_q      <= 1'b1;
              state_q     <= S_SCAN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_SCAN: begin
          if (done_i) err_q <= 1'b1;
          acc_q <= acc_q + {{(CNT_W-1){1'b0}}, hit_s};
          if (idx_q == IDX_LAST) state_q <= S_REPORT;
          else idx_q <= idx_q + IDX_ONE;
        end
        S_REPORT: begin
          if (done_i) err_q <= 1'b1;
          cover_q     <= acc_q;
          chk_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
`ifdef LASER_CHK_BEST_EN
          if (acc_q > best_cnt_q) begin
            best_cnt_q <= acc_q;
            best_c1x_q <= c1x_q;
            best_c1y_q <= c1y_q;
            best_c2x_q <= c2x_q;
            best_c2y_q <= c2y_q;
          end
`endif
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cover_cnt_o = cover_q;
  assign chk_valid_o = chk_valid_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;
  assign ovf_o       = ovf_q;
`ifdef LASER_CHK_BEST_EN
  assign best_cnt_o  = best_cnt_q;
  assign best_c1x_o  = best_c1x_q;
  assign best_c1y_o  = best_c1y_q;
  assign best_c2x_o  = best_c2x_q;
  assign best_c2y_o  = best_c2y_q;
`endif

endmodule

// File: tb/tb_laser_cover_checker.sv
// Directed self-checking bench for laser_cover_checker; honours LASER_CHK_BEST_EN when defined.
module tb_laser_cover_checker;
  logic       clk = 1'b0;
  logic       rst_n, in_valid, done;
  logic [3:0] x, y, c1x, c1y, c2x, c2y;
  logic [5:0] cover_cnt;
  logic       chk_valid, busy, err, ovf;
`ifdef LASER_CHK_BEST_EN
  logic [5:0] best_cnt;
  logic [3:0] best_c1x, best_c1y, best_c2x, best_c2y;
`endif

  int total = 0;
  int passed = 0;
  int pulses = 0;
  logic [3:0] tx [40];
  logic [3:0] ty [40];

  laser_cover_checker dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .x_i(x), .y_i(y), .done_i(done),
    .c1x_i(c1x), .c1y_i(c1y), .c2x_i(c2x), .c2y_i(c2y),
    .cover_cnt_o(cover_cnt), .chk_valid_o(chk_valid), .busy_o(busy), .err_o(err), .ovf_o(ovf)
`ifdef LASER_CHK_BEST_EN
    , .best_cnt_o(best_cnt), .best_c1x_o(best_c1x), .best_c1y_o(best_c1y),
    .best_c2x_o(best_c2x), .best_c2y_o(best_c2y)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (chk_valid === 1'b1) pulses++;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; done = 1'b0;
    x = 4'd0; y = 4'd0; c1x = 4'd0; c1y = 4'd0; c2x = 4'd0; c2y = 4'd0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic fill(input int lo, input int hi, input logic [3:0] px, input logic [3:0] py);
    for (int i = lo; i <= hi; i++) begin tx[i] = px; ty[i] = py; end
  endtask

  task automatic stream();
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; x = tx[i]; y = ty[i];
      tick(1);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_done(input logic [3:0] ax, input logic [3:0] ay, input logic [3:0] bx, input logic [3:0] by);
    done = 1'b1; c1x = ax; c1y = ay; c2x = bx; c2y = by;
    tick(1);
    done = 1'b0;
  endtask

  task automatic wait_report(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      tick(1);
      if (chk_valid === 1'b1) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({cover_cnt, chk_valid, busy, err, ovf} !== 10'd0) begin
      $display("FAIL reset_outputs: got cnt=%0d v=%b b=%b e=%b o=%b required all 0", cover_cnt, chk_valid, busy, err, ovf);
    end else passed++;
  endtask

  task automatic test_basic();
    int lat, p0;
    fill(0, 39, 4'd5, 4'd5);
    stream();
    p0 = pulses;
    send_done(4'd5, 4'd5, 4'd0, 4'd0);
    total++;
    if (busy !== 1'b1) $display("FAIL busy_after_done: got %b required 1", busy); else passed++;
    wait_report(lat);
    total++;
    if (lat !== 41) $display("FAIL basic_latency: got %0d required 41", lat); else passed++;
    total++;
    if (cover_cnt !== 6'd40) $display("FAIL basic_count: got %0d required 40", cover_cnt); else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL busy_after_report: got %b required 0", busy); else passed++;
    tick(5);
    total++;
    if (pulses - p0 !== 1) $display("FAIL basic_pulses: got %0d required 1", pulses - p0); else passed++;
    total++;
    if ({err, ovf} !== 2'b00) $display("FAIL basic_flags: got err=%b ovf=%b required 0 0", err, ovf); else passed++;
  endtask

  task automatic test_boundary();
    int lat;
    fill(0, 39, 4'd0, 4'd15);
    tx[0] = 4'd9;  ty[0] = 4'd5;
    tx[1] = 4'd10; ty[1] = 4'd5;
    tx[2] = 4'd8;  ty[2] = 4'd8;
    stream();
    send_done(4'd5, 4'd5, 4'd15, 4'd15);
    wait_report(lat);
    total++;
    if (lat !== 41 || cover_cnt !== 6'd1) $display("FAIL boundary_count: got cnt=%0d lat=%0d required 1 41", cover_cnt, lat); else passed++;
  endtask

  task automatic test_overlap();
    int lat;
    fill(0, 9, 4'd6, 4'd5);
    fill(10, 14, 4'd2, 4'd5);
    fill(15, 19, 4'd10, 4'd5);
    fill(20, 39, 4'd0, 4'd15);
    stream();
    send_done(4'd5, 4'd5, 4'd7, 4'd5);
    wait_report(lat);
    total++;
    if (lat !== 41 || cover_cnt !== 6'd20) $display("FAIL overlap_count: got cnt=%0d lat=%0d required 20 41", cover_cnt, lat); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat;
    fill(0, 11, 4'd3, 4'd3);
    fill(12, 39, 4'd15, 4'd0);
    stream();
    send_done(4'd3, 4'd3, 4'd0, 4'd0);
    fill(0, 39, 4'd15, 4'd15);
    stream();
    total++;
    if (ovf !== 1'b0) $display("FAIL b2b_no_ovf: got %b required 0", ovf); else passed++;
    wait_report(lat);
    total++;
    if (lat <= 0 || cover_cnt !== 6'd12) $display("FAIL b2b_round1: got cnt=%0d lat=%0d required 12 seen", cover_cnt, lat); else passed++;
    send_done(4'd14, 4'd14, 4'd0, 4'd0);
    wait_report(lat);
    total++;
    if (lat !== 41 || cover_cnt !== 6'd40) $display("FAIL b2b_round2: got cnt=%0d lat=%0d required 40 41", cover_cnt, lat); else passed++;
  endtask

  task automatic test_errors();
    int lat, p0;
    do_reset();
    p0 = pulses;
    send_done(4'd5, 4'd5, 4'd0, 4'd0);
    tick(5);
    total++;
    if (err !== 1'b1 || pulses !== p0) $display("FAIL err_no_bank: got err=%b pulses=%0d required 1 %0d", err, pulses, p0); else passed++;
    do_reset();
    fill(0, 39, 4'd5, 4'd5);
    stream();
    p0 = pulses;
    send_done(4'd5, 4'd5, 4'd0, 4'd0);
    tick(10);
    total++;
    if (err !== 1'b0) $display("FAIL err_before_midscan: got %b required 0", err); else passed++;
    send_done(4'd15, 4'd15, 4'd15, 4'd15);
    total++;
    if (err !== 1'b1) $display("FAIL err_midscan: got %b required 1", err); else passed++;
    wait_report(lat);
    tick(5);
    total++;
    if (cover_cnt !== 6'd40 || pulses - p0 !== 1) $display("FAIL midscan_report: got cnt=%0d pulses=%0d required 40 1", cover_cnt, pulses - p0); else passed++;
    do_reset();
    fill(0, 39, 4'd1, 4'd2);
    stream();
    stream();
    total++;
    if (ovf !== 1'b0) $display("FAIL ovf_at_80: got %b required 0", ovf); else passed++;
    in_valid = 1'b1; tick(1); in_valid = 1'b0;
    total++;
    if (ovf !== 1'b1) $display("FAIL ovf_at_81: got %b required 1", ovf); else passed++;
    in_valid = 1'b1; tick(39); in_valid = 1'b0;
    tick(3);
    total++;
    if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b required 1", ovf); else passed++;
  endtask

  task automatic test_reset_midscan();
    int p0;
    do_reset();
    fill(0, 39, 4'd5, 4'd5);
    stream();
    send_done(4'd5, 4'd5, 4'd0, 4'd0);
    tick(10);
    total++;
    if (busy !== 1'b1) $display("FAIL busy_midscan: got %b required 1", busy); else passed++;
    p0 = pulses;
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    total++;
    if ({cover_cnt, chk_valid, busy, err, ovf} !== 10'd0) begin
      $display("FAIL reset_midscan_outputs: got cnt=%0d v=%b b=%b e=%b o=%b required all 0", cover_cnt, chk_valid, busy, err, ovf);
    end else passed++;
    tick(50);
    total++;
    if (pulses !== p0) $display("FAIL reset_midscan_no_report: got %0d pulses required 0", pulses - p0); else passed++;
  endtask

`ifdef LASER_CHK_BEST_EN
  task automatic test_best();
    int lat;
    do_reset();
    fill(0, 29, 4'd5, 4'd5);
    fill(30, 39, 4'd15, 4'd15);
    stream();
    send_done(4'd5, 4'd5, 4'd2, 4'd0);
    wait_report(lat);
    fill(0, 24, 4'd5, 4'd5);
    fill(25, 39, 4'd15, 4'd15);
    stream();
    send_done(4'd6, 4'd5, 4'd1, 4'd1);
    wait_report(lat);
    total++;
    if (cover_cnt !== 6'd25) $display("FAIL best_round2_cnt: got %0d required 25", cover_cnt); else passed++;
    total++;
    if (best_cnt !== 6'd30 || {best_c1x, best_c1y, best_c2x, best_c2y} !== 16'h5520) begin
      $display("FAIL best_hold: got %0d %h%h%h%h required 30 5520", best_cnt, best_c1x, best_c1y, best_c2x, best_c2y);
    end else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_overlap();
    test_back_to_back();
    test_errors();
    test_reset_midscan();
`ifdef LASER_CHK_BEST_EN
    test_best();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
